// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one single-port synchronous SRAM between the CPU
//            instruction-fetch port and the CPU data port. At most one SRAM
//            access is issued per cycle. Data wins a conflict; with
//            ARB_STARVE_EN defined, a fetch denied STARVE_MAX cycles in a row
//            is forced through. Read data returns to the owning port one
//            cycle after the grant.
// Macro    : ARB_STARVE_EN - enables the fetch anti-starvation counter.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            i_req/i_addr      - fetch request, held until i_gnt
//            i_gnt             - fetch accepted (combinational)
//            i_rvalid/i_rdata  - fetch response (valid registered)
//            d_req/d_we/d_addr/d_wdata - data request, held until d_gnt
//            d_gnt             - data accepted (combinational)
//            d_rvalid/d_rdata  - load response (valid registered)
//            sram_en/sram_we/sram_addr/sram_wdata/sram_rdata - SRAM side
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    // fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // SRAM side
    output logic          sram_en,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    // Response owner tag encoding
    localparam logic [1:0] c_RSP_NONE = 2'd0;
    localparam logic [1:0] c_RSP_INST = 2'd1;
    localparam logic [1:0] c_RSP_DATA = 2'd2;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [1:0] r_rsp_sel;
    logic [1:0] w_rsp_sel_nxt;
    logic       w_force_i;

`ifdef ARB_STARVE_EN
    // Consecutive cycles the fetch port has been kept waiting. Saturates at
    // STARVE_MAX, at which point fetch takes the SRAM for one cycle.
    logic [3:0] r_starve_cnt;

    assign w_force_i = i_req && (r_starve_cnt == c_STARVE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!i_req || i_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`else
    // Strict data priority: no override, the limit is only referenced here.
    logic w_unused_starve_max;
    assign w_unused_starve_max = ^c_STARVE_MAX;
    assign w_force_i           = 1'b0;
`endif

    // Grant selection and owner-tag next state
    always_comb begin
        i_gnt         = 1'b0;
        d_gnt         = 1'b0;
        w_rsp_sel_nxt = c_RSP_NONE;
        if (!reset) begin
            if (w_force_i) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
        if (i_gnt) begin
            w_rsp_sel_nxt = c_RSP_INST;
        end else if (d_gnt && !d_we) begin
            w_rsp_sel_nxt = c_RSP_DATA;
        end
    end

    // SRAM request mux; idle cycles drive zeros
    always_comb begin
        sram_en    = i_gnt | d_gnt;
        sram_we    = d_gnt & d_we;
        sram_addr  = '0;
        sram_wdata = '0;
        if (i_gnt) begin
            sram_addr = i_addr;
        end else if (d_gnt) begin
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_sel <= c_RSP_NONE;
        end else begin
            r_rsp_sel <= w_rsp_sel_nxt;
        end
    end

    // The valid is also gated by reset so that a read granted just before
    // reset asserts never reports a response during reset.
    assign i_rvalid = (r_rsp_sel == c_RSP_INST) && !reset;
    assign d_rvalid = (r_rsp_sel == c_RSP_DATA) && !reset;
    assign i_rdata  = sram_rdata;
    assign d_rdata  = sram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench for sram_port_arbiter. A behavioural SRAM
//            and an arbitration reference model predict grants, SRAM
//            controls and read responses every cycle. Honours ARB_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_EN
    localparam bit c_STARVE_EN     = 1'b1;
    localparam int c_EXP_STARVE_IG = 2;
`else
    localparam bit c_STARVE_EN     = 1'b0;
    localparam int c_EXP_STARVE_IG = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural single-port synchronous SRAM
    logic [DW-1:0] sram_mem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) sram_mem[sram_addr] = sram_wdata;
            else sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : '0;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit            pend_i, pend_d;
    logic [DW-1:0] pend_data;
    int            waitc;
    bit            last_i, last_d;

    // Observed / expected per cycle. ctl = {i_gnt,d_gnt,sram_en,sram_we,i_rvalid,d_rvalid}
    logic [5:0]    obs_ctl, exp_ctl;
    logic [AW-1:0] obs_addr, exp_addr;
    logic [DW-1:0] obs_wdata, exp_wdata, obs_rdata, exp_rdata;
    bit            chk_wdata, chk_rdata;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        ref_mem[a]  = v;
        sram_mem[a] = v;
    endtask

    // One clock cycle: drive, predict from the arbitration rules, sample.
    task automatic step(input bit rst, input bit ir, input logic [AW-1:0] ia,
                        input bit dr, input bit dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd);
        bit ei, ed;
        reset = rst; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        ei = !rst && ir && (!dr || (c_STARVE_EN && waitc >= STARVE_MAX));
        ed = !rst && dr && !ei;
        exp_ctl   = {ei, ed, ei | ed, ed & dw, pend_i & !rst, pend_d & !rst};
        exp_addr  = ei ? ia : (ed ? da : '0);
        chk_wdata = !ei;
        exp_wdata = ed ? dd : '0;
        chk_rdata = (pend_i || pend_d) && !rst;
        exp_rdata = pend_data;
        @(negedge clk);
        obs_ctl   = {i_gnt, d_gnt, sram_en, sram_we, i_rvalid, d_rvalid};
        obs_addr  = sram_addr;
        obs_wdata = sram_wdata;
        obs_rdata = pend_i ? i_rdata : d_rdata;
        pend_data = ei ? ref_rd(ia) : ref_rd(da);
        if (ed && dw) ref_mem[da] = dd;
        pend_i = ei;
        pend_d = ed && !dw;
        waitc  = (!rst && ir && !ei) ? waitc + 1 : 0;
        last_i = ei;
        last_d = ed;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'h0);
            n_cmp++;
            if (obs_ctl !== 6'b0) begin
                n_err++;
                $display("FAIL reset_ctl cyc%0d: got %b want %b", k, obs_ctl, 6'b0);
            end
            n_cmp++;
            if (obs_addr !== exp_addr) begin
                n_err++;
                $display("FAIL reset_addr cyc%0d: got %h want %h", k, obs_addr, exp_addr);
            end
        end
    endtask

    task automatic test_lone_fetch();
        preload(32'h1c000000, 32'h02800421);
        step(1'b0, 1'b1, 32'h1c000000, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (obs_ctl !== exp_ctl) begin
            n_err++;
            $display("FAIL fetch_grant: got %b want %b", obs_ctl, exp_ctl);
        end
        n_cmp++;
        if (obs_addr !== 32'h1c000000) begin
            n_err++;
            $display("FAIL fetch_addr: got %h want %h", obs_addr, 32'h1c000000);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (obs_ctl !== exp_ctl) begin
            n_err++;
            $display("FAIL fetch_rsp_ctl: got %b want %b", obs_ctl, exp_ctl);
        end
        n_cmp++;
        if (obs_rdata !== 32'h02800421) begin
            n_err++;
            $display("FAIL fetch_rdata: got %h want %h", obs_rdata, 32'h02800421);
        end
    endtask

    task automatic test_store_load();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hdeadbeef);
        n_cmp++;
        if (obs_ctl !== exp_ctl || obs_wdata !== 32'hdeadbeef) begin
            n_err++;
            $display("FAIL store: ctl %b want %b, wdata %h want deadbeef", obs_ctl, exp_ctl, obs_wdata);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        n_cmp++;
        if (obs_ctl !== exp_ctl) begin
            n_err++;
            $display("FAIL load_after_store_ctl: got %b want %b", obs_ctl, exp_ctl);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (obs_ctl !== exp_ctl) begin
            n_err++;
            $display("FAIL load_rsp_ctl: got %b want %b", obs_ctl, exp_ctl);
        end
        n_cmp++;
        if (obs_rdata !== 32'hdeadbeef) begin
            n_err++;
            $display("FAIL load_rdata: got %h want %h", obs_rdata, 32'hdeadbeef);
        end
    endtask

    task automatic test_conflict();
        preload(32'h200, 32'h11112222);
        preload(32'h300, 32'h33334444);
        step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0);
        step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (obs_ctl !== exp_ctl) begin
            n_err++;
            $display("FAIL conflict_c2_ctl: got %b want %b", obs_ctl, exp_ctl);
        end
        n_cmp++;
        if (obs_rdata !== 32'h11112222) begin
            n_err++;
            $display("FAIL conflict_data_rsp: got %h want %h", obs_rdata, 32'h11112222);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (obs_ctl !== 6'b000010 || obs_rdata !== 32'h33334444) begin
            n_err++;
            $display("FAIL conflict_inst_rsp: ctl %b want 000010, data %h want 33334444", obs_ctl, obs_rdata);
        end
    endtask

    task automatic test_starvation();
        int ig_cnt = 0;
        int first  = -1;
        preload(32'h40, 32'hcafef00d);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0);
            n_cmp++;
            if (obs_ctl !== exp_ctl || (chk_rdata && obs_rdata !== exp_rdata)) begin
                n_err++;
                $display("FAIL starve cyc%0d: ctl %b want %b, rdata %h want %h", k, obs_ctl, exp_ctl, obs_rdata, exp_rdata);
            end
            if (obs_ctl[5]) begin
                ig_cnt++;
                if (first < 0) first = k;
            end
        end
        n_cmp++;
        if (ig_cnt !== c_EXP_STARVE_IG) begin
            n_err++;
            $display("FAIL starve_fetch_grants: got %0d want %0d (first at %0d)", ig_cnt, c_EXP_STARVE_IG, first);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 32'h1c000000, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 32'h1c000004, 1'b1, 1'b1, 32'h8, 32'h5);
            n_cmp++;
            if (obs_ctl !== 6'b0) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got %b want %b", k, obs_ctl, 6'b0);
            end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (obs_ctl !== 6'b0) begin
            n_err++;
            $display("FAIL reset_mid_after: got %b want %b", obs_ctl, 6'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) preload(32'(4 * k), $urandom);
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b0, 32'h0, k < 8, 1'b0, 32'(4 * k), 32'h0);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin
                n_err++;
                $display("FAIL b2b_ctl cyc%0d: got %b want %b", k, obs_ctl, exp_ctl);
            end
            if (k > 0) begin
                n_cmp++;
                if (obs_rdata !== sram_mem[32'(4 * (k - 1))]) begin
                    n_err++;
                    $display("FAIL b2b_rdata cyc%0d: got %h want %h", k, obs_rdata, sram_mem[32'(4 * (k - 1))]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit            ir = 0, dr = 0, dw = 0;
        logic [AW-1:0] ia = '0, da = '0;
        logic [DW-1:0] dd = '0;
        for (int k = 0; k < 400; k++) begin
            if (!ir) begin
                ir = ($urandom_range(0, 2) != 0);
                ia = 32'(4 * $urandom_range(0, 15));
            end
            if (!dr) begin
                dr = ($urandom_range(0, 2) == 0);
                dw = $urandom_range(0, 1);
                da = 32'(4 * $urandom_range(0, 15));
                dd = $urandom;
            end
            step(1'b0, ir, ia, dr, dw, da, dd);
            n_cmp++;
            if (obs_ctl !== exp_ctl || obs_addr !== exp_addr) begin
                n_err++;
                $display("FAIL rand_ctl cyc%0d: ctl %b want %b, addr %h want %h", k, obs_ctl, exp_ctl, obs_addr, exp_addr);
            end
            if (chk_wdata) begin
                n_cmp++;
                if (obs_wdata !== exp_wdata) begin
                    n_err++;
                    $display("FAIL rand_wdata cyc%0d: got %h want %h", k, obs_wdata, exp_wdata);
                end
            end
            if (chk_rdata) begin
                n_cmp++;
                if (obs_rdata !== exp_rdata) begin
                    n_err++;
                    $display("FAIL rand_rdata cyc%0d: got %h want %h", k, obs_rdata, exp_rdata);
                end
            end
            if (last_i) ir = 0;
            if (last_d) dr = 0;
        end
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        pend_i = 0; pend_d = 0; pend_data = '0; waitc = 0;
        last_i = 0; last_d = 0;
        for (int k = 0; k < 16; k++) preload(32'(4 * k), $urandom);
        @(posedge clk);
        #1;
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_conflict();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
